// File: rtl/apb_master_bridge.sv
// Single-command APB master: command -> SETUP -> ACCESS (wait states, optional timeout) -> held response.
// Zero-wait latency: rsp_valid three cycles after the command handshake; response held until rsp_ready.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic cmd_hs;
  logic timeout_hit;

  // cmd_ready_q is only ever set while in IDLE, so it doubles as the IDLE qualifier
  assign cmd_hs      = cmd_valid & cmd_ready_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pready wins over the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    pselx     = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      SETUP:   pselx = 1'b1;
      ACCESS: begin
        pselx   = 1'b1;
        penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, wait counter, response capture
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    if (cmd_hs) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
      cnt_d    = '0;
    end

    if (state_q == ACCESS) begin
      if (pready) begin
        rsp_err_d   = pslverr;
        rsp_rdata_d = pwrite_q ? '0 : prdata;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      cmd_ready_q <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: per-transaction expected waveform built from phase lengths,
// checked every cycle, plus literal latency/length/data pins per scenario.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          prstn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pselx, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(clk), .prstn(prstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Expected output values for the current cycle
  logic          exp_cmd_ready, exp_rsp_valid, exp_pselx, exp_penable, exp_pwrite, exp_rsp_err;
  logic [AW-1:0] exp_paddr;
  logic [DW-1:0] exp_pwdata, exp_rsp_rdata;

  // Observations used by the literal per-scenario pins
  int            pen_total = 0;
  int            rsp_total = 0;
  int            rsp_rise_cyc = 0;
  logic [DW-1:0] rsp_rd_obs = '0;
  logic          rsp_err_obs = 1'b0;
  logic          rsp_prev = 1'b0;
  int            txn_hs = 0;
  int            txn_pen0 = 0;
  int            txn_rsp0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
    check("pselx",     32'(pselx),     32'(exp_pselx));
    check("penable",   32'(penable),   32'(exp_penable));
    check("pwrite",    32'(pwrite),    32'(exp_pwrite));
    check("paddr",     paddr,          exp_paddr);
    check("pwdata",    32'(pwdata),    32'(exp_pwdata));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp_rdata));
    check("rsp_err",   32'(rsp_err),   32'(exp_rsp_err));
  endtask

  task automatic observe();
    if (penable === 1'b1) pen_total++;
    if (rsp_valid === 1'b1) begin
      rsp_total++;
      if (!rsp_prev) begin
        rsp_rise_cyc = cyc;
        rsp_rd_obs   = rsp_rdata;
        rsp_err_obs  = rsp_err;
      end
    end
    rsp_prev = (rsp_valid === 1'b1);
  endtask

  // One clock cycle: compare mid-cycle, then advance to just after the next rising edge
  task automatic step();
    @(negedge clk);
    if (chk_en) compare_all();
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Values the slave drives when it should be ignored
  task automatic apb_noise();
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 8'hFF;
  endtask

  task automatic exp_reset();
    exp_cmd_ready = 1'b0; exp_rsp_valid = 1'b0; exp_pselx = 1'b0; exp_penable = 1'b0;
    exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0; exp_rsp_rdata = '0; exp_rsp_err = 1'b0;
  endtask

  // waits = pready-low ACCESS cycles before pready rises; rst_k = ACCESS cycle carrying a reset (0 = none)
  task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input logic err,
                         input int bp, input int rst_k);
    bit to_hit;
    int n_acc;
    to_hit   = (TO > 0) && (waits >= TO);
    n_acc    = to_hit ? TO : waits + 1;
    txn_hs   = cyc;
    txn_pen0 = pen_total;
    txn_rsp0 = rsp_total;

    cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wd; rsp_ready = 1'b0;
    apb_noise();
    step();

    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_write = ~wr; cmd_wdata = ~wd;
    exp_cmd_ready = 1'b0; exp_pselx = 1'b1; exp_penable = 1'b0;
    exp_paddr = addr; exp_pwrite = wr; exp_pwdata = wd;
    step();

    for (int k = 1; k <= n_acc; k++) begin
      exp_penable = 1'b1;
      pready  = !to_hit && (k == n_acc);
      pslverr = pready ? err : 1'b1;
      prdata  = pready ? rd : 8'h5A;
      if (k == rst_k) prstn = 1'b0;
      step();
      if (k == rst_k) begin
        exp_reset();
        prstn = 1'b1;
        apb_noise();
        step();
        exp_cmd_ready = 1'b1;
        return;
      end
    end

    apb_noise();
    exp_pselx = 1'b0; exp_penable = 1'b0; exp_rsp_valid = 1'b1;
    exp_rsp_rdata = (to_hit || wr) ? 8'h00 : rd;
    exp_rsp_err   = to_hit ? 1'b1 : err;
    for (int b = 0; b <= bp; b++) begin
      rsp_ready = (b == bp);
      step();
    end
    rsp_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_cmd_ready = 1'b1;
  endtask

  initial begin
    prstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    apb_noise();
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_reset();
    chk_en = 1'b1;
    step();
    prstn = 1'b1;
    step();
    exp_cmd_ready = 1'b1;
    step();

    // Zero-wait write
    run_txn(32'h4, 1'b1, 8'hA5, 0, 8'h00, 1'b0, 0, 0);
    check("wr0_latency",  32'(rsp_rise_cyc - txn_hs), 32'd3);
    check("wr0_penable",  32'(pen_total - txn_pen0), 32'd1);
    check("wr0_rdata",    32'(rsp_rd_obs), 32'h0);

    // Read with 3 wait states
    run_txn(32'h0, 1'b0, 8'h00, 3, 8'h3C, 1'b0, 0, 0);
    check("rd3_penable",  32'(pen_total - txn_pen0), 32'd4);
    check("rd3_rdata",    32'(rsp_rd_obs), 32'h3C);
    check("rd3_err",      32'(rsp_err_obs), 32'h0);

    // Slave error on a read: data still captured
    run_txn(32'h10, 1'b0, 8'h00, 0, 8'h3C, 1'b1, 0, 0);
    check("slverr_err",   32'(rsp_err_obs), 32'h1);
    check("slverr_rdata", 32'(rsp_rd_obs), 32'h3C);
    check("slverr_lat",   32'(rsp_rise_cyc - txn_hs), 32'd3);

    // Timeout: pready never rises
    run_txn(32'h20, 1'b0, 8'h00, 99, 8'h77, 1'b0, 0, 0);
    check("to_penable",   32'(pen_total - txn_pen0), 32'd16);
    check("to_err",       32'(rsp_err_obs), 32'h1);
    check("to_rdata",     32'(rsp_rd_obs), 32'h0);

    // pready on the last allowed ACCESS cycle beats the timeout
    run_txn(32'h30, 1'b0, 8'h00, 15, 8'h81, 1'b0, 0, 0);
    check("edge_penable", 32'(pen_total - txn_pen0), 32'd16);
    check("edge_err",     32'(rsp_err_obs), 32'h0);
    check("edge_rdata",   32'(rsp_rd_obs), 32'h81);

    // Response backpressure for 5 cycles
    run_txn(32'h44, 1'b1, 8'h5E, 1, 8'h00, 1'b0, 5, 0);
    check("bp_rsp_cycles", 32'(rsp_total - txn_rsp0), 32'd6);
    check("bp_penable",    32'(pen_total - txn_pen0), 32'd2);

    // Reset during the second ACCESS cycle
    run_txn(32'h8, 1'b0, 8'h00, 2, 8'h99, 1'b0, 0, 2);
    check("rst_no_rsp",    32'(rsp_total - txn_rsp0), 32'd0);

    // Recovery write after the abort
    run_txn(32'hC, 1'b1, 8'h11, 0, 8'h00, 1'b0, 0, 0);
    check("rec_latency",   32'(rsp_rise_cyc - txn_hs), 32'd3);
    check("rec_penable",   32'(pen_total - txn_pen0), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase length; value 0 disables the timeout.
REQ-004 SHALL have port pclk, input, 1, the single clock, all logic on its rising edge.
REQ-005 SHALL have port prstn, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_ready, output, 1, command accept.
REQ-008 SHALL have port cmd_addr, input, ADDR_WIDTH, target address.
REQ-009 SHALL have port cmd_write, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port cmd_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port rsp_valid, output, 1, response available.
REQ-012 SHALL have port rsp_ready, input, 1, response consumed.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port rsp_err, output, 1, slave error or timeout.
REQ-015 SHALL have port paddr, output, ADDR_WIDTH, APB address.
REQ-016 SHALL have ports pselx, penable and pwrite, each output, 1, APB select, enable and direction.
REQ-017 SHALL have port pwdata, output, DATA_WIDTH, APB write data.
REQ-018 SHALL have ports pready, input, 1, and pslverr, input, 1, APB slave ready and slave error.
REQ-019 SHALL have port prdata, input, DATA_WIDTH, APB read data.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-021 SHALL drive cmd_ready=1 only in IDLE.
REQ-022 SHALL, on a handshake (cmd_valid=1 and cmd_ready=1 at an edge), register cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata, and go to SETUP.
REQ-023 SHALL drive, in SETUP, pselx=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-024 SHALL drive, in ACCESS, pselx=1 and penable=1, holding paddr, pwrite and pwdata stable from SETUP through the end of ACCESS.
REQ-025 SHALL sample pready only in ACCESS; pready=1 ends ACCESS, captures pslverr into rsp_err and captures prdata into rsp_rdata on reads (rsp_rdata=0 on writes), then goes to RESP.
REQ-026 SHALL count ACCESS cycles with pready=0 using a counter cleared on SETUP entry and wide enough to hold TIMEOUT_CYCLES.
REQ-027 SHALL, when TIMEOUT_CYCLES>0 and the ACCESS cycle numbered TIMEOUT_CYCLES ends with pready=0, end ACCESS with rsp_err=1 and rsp_rdata=0, and go to RESP.
REQ-028 SHALL give pready=1 priority over the timeout in the same cycle, so the transfer completes normally.
REQ-029 SHALL drive, in RESP, rsp_valid=1, pselx=0 and penable=0, holding rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-030 SHALL keep rsp_valid low outside RESP and not depend on rsp_ready when asserting it.
REQ-031 SHALL give these latencies: handshake at edge N; SETUP in cycle N+1; first ACCESS in N+2; with zero wait states, rsp_valid=1 in N+3; next cmd_ready=1 one cycle after the response handshake.
REQ-032 SHALL keep paddr, pwrite and pwdata at their last values in IDLE and RESP.
REQ-033 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-034 SHALL keep pselx and penable low in IDLE and RESP, with penable never high while pselx is low.

Reset
REQ-035 SHALL, at any edge with prstn=0, enter IDLE and clear the timeout counter.
REQ-036 SHALL drive these values in reset: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, paddr=0, pwrite=0, pwdata=0, pselx=0, penable=0.
REQ-037 SHALL raise cmd_ready in the first cycle after prstn returns high.
REQ-038 SHALL abort any transfer on reset mid-transfer, with pselx low from the next edge and no response issued.

Verification
REQ-039 SHALL cover a write with zero waits: cmd_addr=0x4, cmd_write=1, cmd_wdata=0xA5, pready=1 -> SETUP then one ACCESS with paddr=0x4 and pwdata=0xA5; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-040 SHALL cover a read with 3 wait states: cmd_addr=0x0, prdata=0x3C when pready rises on the 4th ACCESS cycle -> penable high for 4 cycles, rsp_rdata=0x3C, rsp_err=0.
REQ-041 SHALL cover a slave error: read with pready=1 and pslverr=1 -> rsp_err=1 and rsp_rdata=0x3C sampled.
REQ-042 SHALL cover a timeout: pready held 0 with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, pselx=0.
REQ-043 SHALL cover response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err held, cmd_ready=0 throughout; after the handshake, cmd_ready=1 one cycle later.
REQ-044 SHALL cover reset in ACCESS: prstn=0 for one edge -> all outputs at reset values next cycle, and no rsp_valid pulse.
